adc_serial_tx: RTL and testbench
================================

Name: adc_serial_tx

Overview:
- Serializes parallel ADC-width words into the single-lane serial data plus frame format that the channel LVDS receiver deserializes.
- Used as an in-FPGA ADC emulator for loopback tests of the digitizer channel path, with no external ADC board.
- Sources words from an upstream valid/ready interface, or from internal test patterns (ramp, fixed word).
- Emits one bit per CLK, MSB first, with a 50%-duty FRAME marking word boundaries.

Parameters:
- WIDTH, 12: bits per sample word; must be even and at least 4.
- IDLE_WORD, 12'h000: word sent when data mode underflows.
- FIXED_WORD, 12'hA5C: word sent in fixed-pattern mode.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- ENABLE  input  1  run request; sampled at word boundaries.
- MODE  input  2  source select: 00 data, 01 ramp, 10 fixed, 11 reserved (behaves as fixed).
- DIN  input  WIDTH  upstream sample word.
- DIN_VALID  input  1  DIN holds a valid word.
- DIN_READY  output  1  block accepts DIN this cycle.
- SDATA  output  1  serial data, MSB first.
- FRAME  output  1  high for the first WIDTH/2 bit slots of each word, low for the remaining WIDTH/2.
- BUSY  output  1  high while in RUN.
- UNDERFLOW  output  1  sticky: a data-mode load found DIN_VALID low.
- CLR_STATUS  input  1  synchronous clear of UNDERFLOW and WORD_COUNT.
- WORD_COUNT  output  16  count of words transmitted; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (async, RESET_N=0): state IDLE, bit_cnt=0, shift register=0, ramp=0.
  - Outputs: SDATA=0, FRAME=0, BUSY=0, UNDERFLOW=0, WORD_COUNT=0, DIN_READY=0.
  - Reset mid-word aborts the word immediately; no partial word completes.
- States: IDLE, RUN. SDATA, FRAME and BUSY are registered.
- Load cycle definition: (state==IDLE and ENABLE=1) or (state==RUN and bit_cnt==WIDTH-1 and ENABLE=1).
- At a load cycle:
  - MODE is sampled; MODE changes at any other time have no effect until the next load cycle.
  - Data mode: DIN_READY=1 (combinational from registered state, bit_cnt, ENABLE, MODE). If DIN_VALID=1, load DIN; otherwise load IDLE_WORD and set UNDERFLOW.
  - Ramp mode: load ramp, then ramp <= ramp+1 modulo 2^WIDTH (4095 -> 0). The ramp value persists across IDLE; it is cleared only by reset.
  - Fixed mode: load FIXED_WORD.
  - Next cycle: state=RUN, bit_cnt=0, SDATA=word[WIDTH-1].
- RUN:
  - Each cycle: bit_cnt increments and SDATA shows the next lower bit. FRAME=1 while bit_cnt<WIDTH/2, else 0.
  - WORD_COUNT increments on the cycle bit_cnt==WIDTH-1.
- Back-to-back words have no gap: the word period is exactly WIDTH cycles, and FRAME period is WIDTH cycles.
- Latency: DIN accepted in cycle L; its MSB appears on SDATA in cycle L+1 and its LSB in cycle L+WIDTH.
- ENABLE deasserted mid-word:
  - The current word completes.
  - At bit_cnt==WIDTH-1 with ENABLE=0: no load, DIN_READY=0.
  - Next cycle: state=IDLE, SDATA=0, FRAME=0, BUSY=0.
- In IDLE with ENABLE=0: DIN_READY=0 regardless of MODE; no upstream word is consumed.
- CLR_STATUS:
  - Clears UNDERFLOW and WORD_COUNT on the next edge and takes priority over a simultaneous set or increment.
  - Does not affect transmission.
- Outside data mode, DIN_READY=0 and DIN_VALID is ignored; no underflow is flagged.

Test Plan:
- Reset, then ENABLE=1, MODE=00, DIN=12'hA5C valid at load cycle L -> DIN_READY=1 at L. SDATA over L+1..L+12 = 1,0,1,0,0,1,0,1,1,1,0,0. FRAME=1 for L+1..L+6 and 0 for L+7..L+12. WORD_COUNT=1 after L+12.
- Continuous valid stream 12'h001, 12'h800, 12'hFFF -> DIN_READY pulses every 12 cycles. No idle bits between words; FRAME toggles with period 12. UNDERFLOW stays 0; WORD_COUNT=3.
- Data mode with DIN_VALID=0 at a load cycle -> 12'h000 transmitted and UNDERFLOW=1 sticky. CLR_STATUS pulse -> UNDERFLOW=0 and WORD_COUNT=0 next cycle.
- MODE=01 from reset for 4097 words -> words 0,1,...,4095,0. MODE switched to 10 mid-word -> current ramp word completes, next word is 12'hA5C.
- ENABLE dropped at bit_cnt=3 of a word -> remaining 8 bits still sent. DIN_READY stays 0. IDLE entered the cycle after the LSB, with SDATA=0, FRAME=0, BUSY=0.
- RESET_N asserted at bit_cnt=5 -> all outputs 0 asynchronously. After release with ENABLE=1, the first word starts from a fresh load cycle.

Source files
------------

// File: rtl/adc_serial_tx_if.sv
// Upstream sample stream into adc_serial_tx: one word per DIN_VALID/DIN_READY handshake.
interface adc_serial_tx_if #(
  parameter int WIDTH = 12
);
  logic [WIDTH-1:0] DIN;
  logic             DIN_VALID;
  logic             DIN_READY;

  // Word source (upstream sample producer)
  modport master (output DIN, output DIN_VALID, input DIN_READY);
  // Word sink (the serializer)
  modport slave  (input DIN, input DIN_VALID, output DIN_READY);
endinterface

// File: rtl/adc_serial_tx.sv
// ADC emulator serializer: parallel words -> MSB-first SDATA with a 50%-duty FRAME.
// Words come from the upstream stream, an internal ramp or a fixed pattern.
module adc_serial_tx #(
  parameter int               WIDTH      = 12,
  parameter logic [WIDTH-1:0] IDLE_WORD  = '0,
  parameter logic [WIDTH-1:0] FIXED_WORD = 12'hA5C
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 ENABLE,
  input  logic [1:0]           MODE,
  adc_serial_tx_if.slave       up,
  output logic                 SDATA,
  output logic                 FRAME,
  output logic                 BUSY,
  output logic                 UNDERFLOW,
  input  logic                 CLR_STATUS,
  output logic [15:0]          WORD_COUNT
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  HALF = CW'(WIDTH / 2);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q;
  logic [CW-1:0]    bit_cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] ramp_q;
  logic             frame_q;
  logic             busy_q;
  logic             underflow_q;
  logic [15:0]      word_cnt_q;

  logic             last_bit;
  logic             load;
  logic             data_mode;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] load_word_d;

  // A word boundary is either leaving IDLE or the LSB slot of the current word.
  assign last_bit  = (state_q == S_RUN) && (bit_cnt_q == LAST);
  assign load      = ENABLE && ((state_q == S_IDLE) || last_bit);
  assign data_mode = (MODE == 2'b00);
  assign cnt_nxt   = bit_cnt_q + CW'(1);

  // Ready is gated by reset so nothing upstream is consumed while held in reset.
  assign up.DIN_READY = RESET_N && load && data_mode;

  // Select the word to load at a boundary; reserved MODE 11 acts as fixed.
  always_comb begin
    load_word_d = FIXED_WORD;
    case (MODE)
      2'b00:   load_word_d = up.DIN_VALID ? up.DIN : IDLE_WORD;
      2'b01:   load_word_d = ramp_q;
      default: load_word_d = FIXED_WORD;
    endcase
  end

  // Serializer FSM: SDATA is the shift register MSB, so it is registered and zero when idle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ramp_q    <= '0;
      frame_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else if (load) begin
      state_q   <= S_RUN;
      bit_cnt_q <= '0;
      shift_q   <= load_word_d;
      frame_q   <= 1'b1;
      busy_q    <= 1'b1;
      if (MODE == 2'b01) ramp_q <= ramp_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end else if (state_q == S_RUN) begin
      if (last_bit) begin
        state_q   <= S_IDLE;
        bit_cnt_q <= '0;
        shift_q   <= '0;
        frame_q   <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        bit_cnt_q <= cnt_nxt;
        shift_q   <= {shift_q[WIDTH-2:0], 1'b0};
        frame_q   <= (cnt_nxt < HALF);
      end
    end
  end

  // Status: sticky underflow and wrapping word counter; clear wins over set/increment.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      underflow_q <= 1'b0;
      word_cnt_q  <= '0;
    end else if (CLR_STATUS) begin
      underflow_q <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      if (load && data_mode && !up.DIN_VALID) underflow_q <= 1'b1;
      if (last_bit) word_cnt_q <= word_cnt_q + 16'd1;
    end
  end

  assign SDATA      = shift_q[WIDTH-1];
  assign FRAME      = frame_q;
  assign BUSY       = busy_q;
  assign UNDERFLOW  = underflow_q;
  assign WORD_COUNT = word_cnt_q;

endmodule

// File: tb/tb_adc_serial_tx.sv
// Directed bench for adc_serial_tx: table of back-to-back words plus hand-written corner sequences.
module tb_adc_serial_tx;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        ENABLE = 1'b0;
  logic [1:0]  MODE = 2'b00;
  logic        CLR_STATUS = 1'b0;
  logic        SDATA, FRAME, BUSY, UNDERFLOW;
  logic [15:0] WORD_COUNT;

  adc_serial_tx_if #(.WIDTH(12)) up ();

  adc_serial_tx #(.WIDTH(12)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .ENABLE     (ENABLE),
    .MODE       (MODE),
    .up         (up),
    .SDATA      (SDATA),
    .FRAME      (FRAME),
    .BUSY       (BUSY),
    .UNDERFLOW  (UNDERFLOW),
    .CLR_STATUS (CLR_STATUS),
    .WORD_COUNT (WORD_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  mode;
    logic [11:0] din;
    logic        vld;
    logic [11:0] exp_word;
    logic        exp_rdy;
    logic        exp_uf;
  } vec_t;

  localparam logic [11:0] FRAME_PAT = 12'hFC0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Capture one word: 12 samples on falling edges, with optional mid-word actions.
  task automatic rx_word(input int drop_k, input int msw_k, input logic [1:0] msw_v,
                         output logic [11:0] w, output logic [11:0] f,
                         output logic bok, output logic rmid);
    w = '0; f = '0; bok = 1'b1; rmid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      w = {w[10:0], SDATA};
      f = {f[10:0], FRAME};
      if (!BUSY) bok = 1'b0;
      if (k < 11 && up.DIN_READY) rmid = 1'b1;
      if (k == drop_k) ENABLE = 1'b0;
      if (k == msw_k)  MODE = msw_v;
    end
  endtask

  initial begin
    vec_t        vt [10];
    logic [11:0] w, f;
    logic        bok, rmid;
    int          errs;
    logic [11:0] w4095, w4096;

    //           mode   din      vld   word     rdy   uf
    vt[0] = '{2'b00, 12'hA5C, 1'b1, 12'hA5C, 1'b1, 1'b0};
    vt[1] = '{2'b00, 12'h001, 1'b1, 12'h001, 1'b1, 1'b0};
    vt[2] = '{2'b00, 12'h800, 1'b1, 12'h800, 1'b1, 1'b0};
    vt[3] = '{2'b00, 12'hFFF, 1'b1, 12'hFFF, 1'b1, 1'b0};
    vt[4] = '{2'b01, 12'h123, 1'b0, 12'h000, 1'b0, 1'b0};
    vt[5] = '{2'b10, 12'h123, 1'b0, 12'hA5C, 1'b0, 1'b0};
    vt[6] = '{2'b11, 12'h123, 1'b1, 12'hA5C, 1'b0, 1'b0};
    vt[7] = '{2'b01, 12'h777, 1'b0, 12'h001, 1'b0, 1'b0};
    vt[8] = '{2'b00, 12'h5A5, 1'b0, 12'h000, 1'b1, 1'b1};
    vt[9] = '{2'b01, 12'h5A5, 1'b1, 12'h002, 1'b0, 1'b1};

    // Reset state, with a data-mode run request pending during reset
    up.DIN = 12'h3C3; up.DIN_VALID = 1'b1; ENABLE = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_sdata", SDATA, 0);
    chk("rst_frame", FRAME, 0);
    chk("rst_busy",  BUSY, 0);
    chk("rst_uf",    UNDERFLOW, 0);
    chk("rst_wc",    WORD_COUNT, 0);
    chk("rst_ready", up.DIN_READY, 0);
    ENABLE = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    #1;
    chk("idle_noen_ready", up.DIN_READY, 0);
    chk("idle_busy", BUSY, 0);

    // Back-to-back words from the table
    for (int i = 0; i < 10; i++) begin
      MODE = vt[i].mode; up.DIN = vt[i].din; up.DIN_VALID = vt[i].vld; ENABLE = 1'b1;
      #1;
      chk($sformatf("v%0d_ready", i), up.DIN_READY, vt[i].exp_rdy);
      rx_word(-1, -1, 2'b00, w, f, bok, rmid);
      chk($sformatf("v%0d_word", i), w, vt[i].exp_word);
      chk($sformatf("v%0d_frame", i), f, FRAME_PAT);
      chk($sformatf("v%0d_busy", i), bok, 1);
      chk($sformatf("v%0d_midready", i), rmid, 0);
      chk($sformatf("v%0d_uf", i), UNDERFLOW, vt[i].exp_uf);
      chk($sformatf("v%0d_wc", i), WORD_COUNT, i);
    end

    // Stop at the boundary, idle outputs, then clear status
    ENABLE = 1'b0;
    #1;
    chk("stop_ready", up.DIN_READY, 0);
    @(negedge CLK);
    chk("stop_sdata", SDATA, 0);
    chk("stop_frame", FRAME, 0);
    chk("stop_busy",  BUSY, 0);
    chk("stop_wc",    WORD_COUNT, 10);
    chk("stop_uf",    UNDERFLOW, 1);
    MODE = 2'b00; up.DIN_VALID = 1'b1;
    #1;
    chk("idle_data_noen_ready", up.DIN_READY, 0);
    CLR_STATUS = 1'b1;
    @(negedge CLK);
    CLR_STATUS = 1'b0;
    chk("clr_uf", UNDERFLOW, 0);
    chk("clr_wc", WORD_COUNT, 0);

    // Mode switched mid ramp word: current word completes, next is the fixed word
    MODE = 2'b01; ENABLE = 1'b1;
    rx_word(-1, 5, 2'b10, w, f, bok, rmid);
    chk("msw_ramp_word", w, 12'h003);
    #1;
    chk("msw_fixed_ready", up.DIN_READY, 0);
    // Enable dropped at bit_cnt=3: remaining bits still go out
    rx_word(3, -1, 2'b00, w, f, bok, rmid);
    chk("drop_word",  w, 12'hA5C);
    chk("drop_frame", f, FRAME_PAT);
    chk("drop_busy",  bok, 1);
    chk("drop_midready", rmid, 0);
    #1;
    chk("drop_last_ready", up.DIN_READY, 0);
    @(negedge CLK);
    chk("drop_idle_sdata", SDATA, 0);
    chk("drop_idle_frame", FRAME, 0);
    chk("drop_idle_busy",  BUSY, 0);
    chk("drop_wc", WORD_COUNT, 2);

    // Reset at bit_cnt=5 of an underflowing word
    MODE = 2'b00; up.DIN_VALID = 1'b0; ENABLE = 1'b1;
    #1;
    chk("ufw_ready", up.DIN_READY, 1);
    repeat (6) @(negedge CLK);
    chk("pre_rst_uf", UNDERFLOW, 1);
    chk("pre_rst_busy", BUSY, 1);
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_sdata", SDATA, 0);
    chk("mid_rst_frame", FRAME, 0);
    chk("mid_rst_busy",  BUSY, 0);
    chk("mid_rst_uf",    UNDERFLOW, 0);
    chk("mid_rst_wc",    WORD_COUNT, 0);
    chk("mid_rst_ready", up.DIN_READY, 0);
    @(negedge CLK);
    @(negedge CLK);
    up.DIN = 12'h3C3; up.DIN_VALID = 1'b1;
    RESET_N = 1'b1;
    #1;
    chk("post_rst_ready", up.DIN_READY, 1);
    rx_word(-1, -1, 2'b00, w, f, bok, rmid);
    chk("post_rst_word",  w, 12'h3C3);
    chk("post_rst_frame", f, FRAME_PAT);
    chk("post_rst_uf",    UNDERFLOW, 0);

    // Ramp from reset over 4097 words: 0..4095 then wraps to 0
    MODE = 2'b01;
    errs = 0; w4095 = '0; w4096 = '1;
    for (int n = 0; n < 4097; n++) begin
      rx_word(-1, -1, 2'b00, w, f, bok, rmid);
      if (w !== 12'(n)) errs++;
      if (n == 4095) w4095 = w;
      if (n == 4096) w4096 = w;
    end
    ENABLE = 1'b0;
    chk("ramp_errs", errs, 0);
    chk("ramp_4095", w4095, 12'hFFF);
    chk("ramp_wrap", w4096, 12'h000);
    @(negedge CLK);
    chk("ramp_wc", WORD_COUNT, 16'd4098);
    chk("ramp_idle_busy", BUSY, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
